// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder_pkg : shared types and helpers for the data-memory responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } ext_state_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   function automatic logic is_ext_region(input logic [31:0] addr, input logic [31:0] base);
      return (addr >= base);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ext_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_ext_ctrl : external req/ack sequencer with timeout and read capture
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_ext_ctrl
   import dmem_responder_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ext_hit,
   input  logic        i_we,
   input  logic [29:0] i_addr_word,
   input  logic [31:0] i_wdata,
   input  logic        i_ext_ack,
   input  logic [31:0] i_ext_rdata,
   output logic        o_exstall,
   output logic        o_done,
   output logic [31:0] o_capture,
   output logic        o_ext_req,
   output logic        o_ext_we,
   output logic [31:0] o_ext_addr,
   output logic [31:0] o_ext_wdata,
   output logic        o_err
);

   // r_count holds the number of REQ cycles already spent without an ack
   localparam logic [7:0] c_last_count = 8'(TIMEOUT - 1);

   ext_state_t  r_state;
   logic [7:0]  r_count;
   logic [31:0] r_capture;
   logic        r_ext_req;
   logic        r_ext_we;
   logic [31:0] r_ext_addr;
   logic [31:0] r_ext_wdata;
   logic        r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_capture   <= '0;
         r_ext_req   <= 1'b0;
         r_ext_we    <= 1'b0;
         r_ext_addr  <= '0;
         r_ext_wdata <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_ext_hit) begin
                  r_state     <= ST_REQ;
                  r_count     <= '0;
                  r_ext_req   <= 1'b1;
                  r_ext_we    <= i_we;
                  r_ext_addr  <= {i_addr_word, 2'b00};
                  r_ext_wdata <= i_wdata;
               end
            end
            ST_REQ: begin
               // An ack in the final allowed cycle beats the timeout
               if (i_ext_ack) begin
                  r_state   <= ST_DONE;
                  r_ext_req <= 1'b0;
                  if (!r_ext_we) begin
                     r_capture <= i_ext_rdata;
                  end
               end else if (r_count == c_last_count) begin
                  r_state   <= ST_DONE;
                  r_ext_req <= 1'b0;
                  r_capture <= TIMEOUT_DATA;
                  r_err     <= 1'b1;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_exstall   = !rst && (((r_state == ST_IDLE) && i_ext_hit) || (r_state == ST_REQ));
   assign o_done      = (r_state == ST_DONE);
   assign o_capture   = r_capture;
   assign o_ext_req   = r_ext_req;
   assign o_ext_we    = r_ext_we;
   assign o_ext_addr  = r_ext_addr;
   assign o_ext_wdata = r_ext_wdata;
   assign o_err       = r_err;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : core data-port responder, local word SRAM plus external port
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] EXT_BASE = 32'h8000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read_en,
   input  logic        i_write_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data,
   output logic        o_exstall,
   output logic        o_ext_req,
   output logic        o_ext_we,
   output logic [31:0] o_ext_addr,
   output logic [31:0] o_ext_wdata,
   input  logic        i_ext_ack,
   input  logic [31:0] i_ext_rdata,
   output logic        o_err
);

   localparam int c_idx_w = $clog2(DEPTH);

   logic [31:0]        r_mem [DEPTH];
   logic               w_ext_sel;
   logic               w_ext_hit;
   logic               w_local_we;
   logic [c_idx_w-1:0] w_idx;
   logic               w_done;
   logic [31:0]        w_capture;
   logic [31:0]        w_read_data;

   assign w_ext_sel  = is_ext_region(i_addr, EXT_BASE);
   assign w_ext_hit  = w_ext_sel && (i_read_en || i_write_en);
   assign w_local_we = i_write_en && !w_ext_sel;
   assign w_idx      = i_addr[c_idx_w+1:2];

   always_ff @(posedge clk) begin
      if (w_local_we) begin
         r_mem[w_idx] <= i_write_data;
      end
   end

   // A write (or a read colliding with one) never returns data
   always_comb begin
      w_read_data = '0;
      if (i_read_en && !i_write_en) begin
         if (w_done) begin
            w_read_data = w_capture;
         end else if (!w_ext_sel) begin
            w_read_data = r_mem[w_idx];
         end
      end
   end

   assign o_read_data = w_read_data;

   dmem_ext_ctrl #(
      .TIMEOUT (TIMEOUT)
   ) u_ext_ctrl (
      .clk         (clk),
      .rst         (rst),
      .i_ext_hit   (w_ext_hit),
      .i_we        (i_write_en),
      .i_addr_word (i_addr[31:2]),
      .i_wdata     (i_write_data),
      .i_ext_ack   (i_ext_ack),
      .i_ext_rdata (i_ext_rdata),
      .o_exstall   (o_exstall),
      .o_done      (w_done),
      .o_capture   (w_capture),
      .o_ext_req   (o_ext_req),
      .o_ext_we    (o_ext_we),
      .o_ext_addr  (o_ext_addr),
      .o_ext_wdata (o_ext_wdata),
      .o_err       (o_err)
   );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder : randomized self-checking bench for dmem_responder
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int          DEPTH    = 1024;
   localparam int          TIMEOUT  = 8;
   localparam logic [31:0] EXT_BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read_en = 1'b0;
   logic        write_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        exstall;
   logic        ext_req;
   logic        ext_we;
   logic [31:0] ext_addr;
   logic [31:0] ext_wdata;
   logic        ext_ack = 1'b0;
   logic [31:0] ext_rdata = '0;
   logic        err;

   int          checks = 0;
   int          failures = 0;
   bit          model_err = 1'b0;
   logic [31:0] model_mem [int unsigned];
   logic [31:0] written_q [$];

   dmem_responder #(
      .DEPTH    (DEPTH),
      .EXT_BASE (EXT_BASE),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_read_en    (read_en),
      .i_write_en   (write_en),
      .i_addr       (addr),
      .i_write_data (write_data),
      .o_read_data  (read_data),
      .o_exstall    (exstall),
      .o_ext_req    (ext_req),
      .o_ext_we     (ext_we),
      .o_ext_addr   (ext_addr),
      .o_ext_wdata  (ext_wdata),
      .i_ext_ack    (ext_ack),
      .i_ext_rdata  (ext_rdata),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic int unsigned word_of(input logic [31:0] a);
      return (a / 4) % DEPTH;
   endfunction

   task automatic local_write(input logic [31:0] a, input logic [31:0] d);
      read_en = 1'b0; write_en = 1'b1; addr = a; write_data = d;
      #1;
      checks++;
      if (exstall !== 1'b0) begin
         failures++; $display("FAIL local_write_stall: got %b required 0 (addr %h)", exstall, a);
      end
      checks++;
      if (read_data !== 32'h0) begin
         failures++; $display("FAIL local_write_rdata: got %h required 0", read_data);
      end
      @(posedge clk); #1;
      write_en = 1'b0;
      model_mem[word_of(a)] = d;
      written_q.push_back(a);
   endtask

   task automatic local_read(input logic [31:0] a);
      read_en = 1'b1; write_en = 1'b0; addr = a;
      #1;
      checks++;
      if (exstall !== 1'b0) begin
         failures++; $display("FAIL local_read_stall: got %b required 0 (addr %h)", exstall, a);
      end
      if (model_mem.exists(word_of(a))) begin
         checks++;
         if (read_data !== model_mem[word_of(a)]) begin
            failures++;
            $display("FAIL local_read_data: addr %h got %h required %h", a, read_data, model_mem[word_of(a)]);
         end
      end
      @(posedge clk); #1;
      read_en = 1'b0;
   endtask

   // ack_after = k means ack is driven during the k-th REQ cycle; 0 means never
   task automatic ext_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int ack_after);
      int          stalls = 0;
      int          req_cycles = 0;
      int          req_rises = 0;
      bit          prev_req = 1'b0;
      bit          done_seen = 1'b0;
      bit          timed_out;
      int          exp_stalls;
      logic [31:0] exp_data;
      timed_out  = (ack_after < 1) || (ack_after > TIMEOUT);
      exp_stalls = timed_out ? TIMEOUT + 1 : ack_after + 1;
      exp_data   = we ? 32'h0 : (timed_out ? 32'hDEAD_BEEF : rd);
      read_en = !we; write_en = we; addr = a; write_data = wd;
      for (int c = 0; c < TIMEOUT + 20; c++) begin
         #1;
         if (!exstall) begin
            done_seen = 1'b1;
            break;
         end
         stalls++;
         if (ext_req) begin
            if (!prev_req) req_rises++;
            req_cycles++;
            checks++;
            if (ext_we !== we || ext_addr !== {a[31:2], 2'b00} || (we && ext_wdata !== wd)) begin
               failures++;
               $display("FAIL ext_port: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                        ext_we, ext_addr, ext_wdata, we, {a[31:2], 2'b00}, wd);
            end
            if (req_cycles == ack_after) begin
               ext_ack = 1'b1; ext_rdata = rd;
            end
         end
         prev_req = ext_req;
         @(posedge clk); #1;
         ext_ack = 1'b0; ext_rdata = $urandom;
      end
      if (timed_out) model_err = 1'b1;
      checks++;
      if (!done_seen) begin
         failures++; $display("FAIL ext_done: stall still high after %0d cycles, required release", stalls);
      end
      checks++;
      if (stalls != exp_stalls) begin
         failures++; $display("FAIL ext_stall_len: got %0d cycles required %0d", stalls, exp_stalls);
      end
      checks++;
      if (req_rises != 1) begin
         failures++; $display("FAIL ext_req_pulses: got %0d required 1", req_rises);
      end
      checks++;
      if (ext_req !== 1'b0) begin
         failures++; $display("FAIL ext_req_in_done: got %b required 0", ext_req);
      end
      checks++;
      if (read_data !== exp_data) begin
         failures++; $display("FAIL ext_done_data: got %h required %h", read_data, exp_data);
      end
      checks++;
      if (err !== model_err) begin
         failures++; $display("FAIL ext_err: got %b required %b", err, model_err);
      end
      @(posedge clk); #1;
      read_en = 1'b0; write_en = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      #1;
      checks++;
      if (ext_req !== 1'b0 || exstall !== 1'b0) begin
         failures++; $display("FAIL %s: req=%b stall=%b required 0/0", tag, ext_req, exstall);
      end
      @(posedge clk); #1;
      checks++;
      if (ext_req !== 1'b0) begin
         failures++; $display("FAIL %s_restart: req=%b required 0", tag, ext_req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exstall !== 1'b0 || ext_req !== 1'b0 || ext_we !== 1'b0 || ext_addr !== 32'h0 ||
          ext_wdata !== 32'h0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: stall=%b req=%b we=%b addr=%h wdata=%h err=%b required all 0",
                  exstall, ext_req, ext_we, ext_addr, ext_wdata, err);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("post_reset_idle");
   endtask

   task automatic test_local();
      logic [31:0] a;
      local_write(32'h0000_0010, 32'h1234_5678);
      local_read(32'h0000_0010);
      for (int i = 0; i < 12; i++) begin
         a = $urandom & 32'h7FFF_FFFF;
         local_write(a, $urandom);
         local_read(a);
         local_read(written_q[$urandom_range(0, written_q.size() - 1)]);
      end
   endtask

   task automatic test_wrap_and_conflict();
      logic [31:0] y;
      local_write(DEPTH * 4 + 4, 32'h0BAD_F00D);
      local_read(32'h0000_0004);
      y = $urandom;
      read_en = 1'b1; write_en = 1'b1; addr = 32'h0000_0020; write_data = y;
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         failures++; $display("FAIL rw_conflict_data: got %h required 0", read_data);
      end
      @(posedge clk); #1;
      model_mem[word_of(32'h20)] = y;
      read_en = 1'b0; write_en = 1'b0;
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         failures++; $display("FAIL no_enable_data: got %h required 0", read_data);
      end
      @(posedge clk); #1;
      local_read(32'h0000_0020);
   endtask

   task automatic test_ext_directed();
      ext_access(1'b0, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 3);
      check_idle("after_ext_read");
      ext_access(1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 32'h0, 1);
      check_idle("after_ext_write");
      ext_access(1'b0, 32'h8000_0010, 32'h0, 32'h5555_AAAA, TIMEOUT);
   endtask

   task automatic test_ext_random();
      for (int i = 0; i < 6; i++) begin
         ext_access(1'($urandom_range(0, 1)), EXT_BASE | $urandom, $urandom, $urandom,
                    $urandom_range(1, TIMEOUT));
      end
      check_idle("after_ext_random");
   endtask

   task automatic test_back_to_back();
      ext_access(1'b0, 32'hF000_0100, 32'h0, 32'h1111_2222, 2);
      ext_access(1'b0, 32'hF000_0200, 32'h0, 32'h3333_4444, 1);
      ext_access(1'b1, 32'hF000_0300, 32'h7777_8888, 32'h0, 4);
      check_idle("after_back_to_back");
   endtask

   task automatic test_stray_ack();
      ext_ack = 1'b1; ext_rdata = $urandom;
      #1;
      checks++;
      if (exstall !== 1'b0) begin
         failures++; $display("FAIL stray_ack_stall: got %b required 0", exstall);
      end
      @(posedge clk); #1;
      ext_ack = 1'b0;
      check_idle("stray_ack");
      local_read(32'h0000_0010);
   endtask

   task automatic test_timeout();
      ext_access(1'b0, 32'h8000_0040, 32'h0, 32'h0, 0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b1) begin
         failures++; $display("FAIL err_sticky: got %b required 1", err);
      end
      @(posedge clk); #1;
      ext_access(1'b0, 32'h8000_0044, 32'h0, 32'h6666_7777, 2);
   endtask

   task automatic test_reset_mid_transfer();
      read_en = 1'b1; addr = 32'h8000_0100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (ext_req !== 1'b1) begin
         failures++; $display("FAIL mid_req_up: got %b required 1", ext_req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ext_req !== 1'b0 || exstall !== 1'b0 || err !== 1'b0 || ext_addr !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset: req=%b stall=%b err=%b addr=%h required 0/0/0/0",
                  ext_req, exstall, err, ext_addr);
      end
      read_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_err = 1'b0;
      check_idle("after_mid_reset");
      ext_access(1'b0, 32'h8000_0100, 32'h0, 32'h1357_9BDF, 3);
   endtask

   initial begin
      test_reset();
      test_local();
      test_wrap_and_conflict();
      test_ext_directed();
      test_ext_random();
      test_back_to_back();
      test_stray_ack();
      test_timeout();
      test_reset_mid_transfer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
